// File: rtl/ftwb_blink_pkg.sv
// Shared definitions for the blink/toggle rate link.
// Speed encoding helpers and decoder state type.
package ftwb_blink_pkg;

    localparam int SPEED_W    = 4;
    localparam int NUM_SPEEDS = 16;
    localparam int UNITS_W    = 5;

    typedef enum logic [0:0] {
        S_WAIT_EDGE = 1'b0,
        S_MEASURE   = 1'b1
    } decoder_state_t;

    // Half-period of the toggle waveform for a given speed setting.
    function automatic int unsigned half_period_cycles(
        input logic [SPEED_W-1:0] speed,
        input int unsigned        base
    );
        int unsigned steps;
        steps = NUM_SPEEDS - {28'd0, speed};
        return base * steps;
    endfunction

endpackage

// File: rtl/toggle_sync_edge.sv
// Synchroniser plus any-edge detector for an asynchronous level.
// Ports: clk, rst_n, async_in -> sync_out (level), edge_pulse (1 cycle).
module toggle_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            edge_pulse <= sync_q[SYNC_STAGES-1] ^ prev_q;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_rate_decoder.sv
// Recovers the 4-bit speed from a rate-coded toggle waveform.
// Ports: clk, rst_n, toggle_in -> speed_out, speed_valid, rate_err, edge_pulse.
module toggle_rate_decoder
    import ftwb_blink_pkg::*;
#(
    parameter int BASE_CYCLES = 3_125_000,
    parameter int LOCK_COUNT  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               toggle_in,
    output logic [SPEED_W-1:0] speed_out,
    output logic               speed_valid,
    output logic               rate_err,
    output logic               edge_pulse
);

    localparam int FRAC_W  = $clog2(BASE_CYCLES);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [FRAC_W-1:0]  FRAC_HALF  = FRAC_W'(BASE_CYCLES / 2);
    localparam logic [FRAC_W-1:0]  FRAC_LAST  = FRAC_W'(BASE_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
    localparam logic [UNITS_W-1:0] UNITS_MAX  = UNITS_W'(NUM_SPEEDS);

    if (BASE_CYCLES < 2) begin : g_bad_base
        $error("BASE_CYCLES must be >= 2");
    end
    if (LOCK_COUNT < 1) begin : g_bad_lock
        $error("LOCK_COUNT must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end

    decoder_state_t      state_q, state_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [UNITS_W-1:0]  units_q, units_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [SPEED_W-1:0]  prev_cand_q, prev_cand_d;
    logic [SPEED_W-1:0]  speed_d;
    logic                valid_d;
    logic                err_d;

    logic                sync_lvl_unused;
    logic [SPEED_W-1:0]  cand;
    logic [MATCH_W-1:0]  match_inc;
    logic [MATCH_W-1:0]  match_new;
    logic                units_bad;

    toggle_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (toggle_in),
        .sync_out  (sync_lvl_unused),
        .edge_pulse(edge_pulse)
    );

    // 16 - units modulo 16; units==16 maps to speed 0.
    assign cand      = SPEED_W'(0) - units_q[SPEED_W-1:0];
    assign units_bad = (units_q == '0) || (units_q > UNITS_MAX);
    assign match_inc = (match_q == MATCH_LOCK) ? MATCH_LOCK
                                               : match_q + 1'b1;
    assign match_new = (cand == prev_cand_q) ? match_inc : MATCH_ONE;

    always_comb begin
        state_d     = state_q;
        frac_d      = frac_q;
        units_d     = units_q;
        match_d     = match_q;
        prev_cand_d = prev_cand_q;
        speed_d     = speed_out;
        valid_d     = speed_valid;
        err_d       = rate_err;

        unique case (state_q)
            S_WAIT_EDGE: begin
                if (edge_pulse) begin
                    frac_d  = FRAC_HALF;
                    units_d = '0;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (edge_pulse) begin
                    // Edge wins over a simultaneous frac wrap.
                    frac_d  = FRAC_HALF;
                    units_d = '0;
                    if (units_bad) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        match_d = '0;
                    end else begin
                        match_d     = match_new;
                        prev_cand_d = cand;
                        if (match_new == MATCH_LOCK) begin
                            speed_d = cand;
                            valid_d = 1'b1;
                            err_d   = 1'b0;
                        end else if (cand != speed_out) begin
                            valid_d = 1'b0;
                        end
                    end
                end else if (frac_q == FRAC_LAST) begin
                    frac_d = '0;
                    if (units_q >= UNITS_MAX) begin
                        // Stalled input: park units at 17, drop lock.
                        units_d = UNITS_MAX + 1'b1;
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        match_d = '0;
                        state_d = S_WAIT_EDGE;
                    end else begin
                        units_d = units_q + 1'b1;
                    end
                end else begin
                    frac_d = frac_q + 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT_EDGE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT_EDGE;
            frac_q      <= '0;
            units_q     <= '0;
            match_q     <= '0;
            prev_cand_q <= '0;
            speed_out   <= '0;
            speed_valid <= 1'b0;
            rate_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            frac_q      <= frac_d;
            units_q     <= units_d;
            match_q     <= match_d;
            prev_cand_q <= prev_cand_d;
            speed_out   <= speed_d;
            speed_valid <= valid_d;
            rate_err    <= err_d;
        end
    end

endmodule

// File: doc/toggle_rate_decoder.md
Name: toggle_rate_decoder

Overview:
- Receive end of the blink/toggle interface: takes the square wave produced by the speed-programmable counter and recovers the 4-bit speed setting that generated it.
- Measures cycles between successive toggle edges. Rounds the measurement to the nearest multiple of BASE_CYCLES without a divider, then maps it back to speed.
- Reports the speed once it is stable. Flags out-of-range or stalled input.
- Used for loopback self-test of the blinker and for decoding a rate-coded status line from another board.

Parameters:
- BASE_CYCLES, 3_125_000, clk cycles per speed step. Must be ≥ 2. Set to 10 in simulation.
- LOCK_COUNT, 2, consecutive identical decodes required before speed_valid asserts. Must be ≥ 1.
- SYNC_STAGES, 2, flip-flops in the toggle_in synchroniser. Must be ≥ 2.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- toggle_in  in  1  toggle waveform, possibly asynchronous to clk
- speed_out  out  4  last locked decoded speed
- speed_valid  out  1  speed_out matches the current input rate
- rate_err  out  1  sticky until the next valid decode: last interval was out of range or timed out
- edge_pulse  out  1  one-cycle pulse per synchronised edge (rising or falling) of toggle_in

Behaviour:
- Rate encoding (shared with the transmitter):
  - Half-period in cycles = BASE_CYCLES × (16 − speed).
  - Speed 15 is the fastest (1 × BASE); speed 0 is the slowest (16 × BASE).
- Reset (async assert, sync deassert by the consumer):
  - speed_out=0, speed_valid=0, rate_err=0, edge_pulse=0.
  - All synchroniser flops and the edge-history flop = 0. FSM=S_WAIT_EDGE, match_cnt=0, units=0.
- Edge detection:
  - toggle_in passes through SYNC_STAGES flops.
  - edge_pulse=1 when the last synchronised bit differs from the registered previous bit.
  - Latency: SYNC_STAGES+1 cycles from a toggle_in transition to edge_pulse.
- FSM states:
  - S_WAIT_EDGE: no reference edge yet. On edge_pulse: load frac_cnt=BASE_CYCLES/2 (integer division), units=0, go to S_MEASURE. No decode.
  - S_MEASURE, each cycle without edge_pulse:
    - If frac_cnt==BASE_CYCLES−1: frac_cnt←0 and units←units+1. Otherwise frac_cnt←frac_cnt+1.
    - Result: units = floor((interval + BASE/2) / BASE), i.e. ±BASE/2 tolerance.
  - S_MEASURE, on edge_pulse:
    - Decode, then reload frac_cnt=BASE/2, units=0, and stay in S_MEASURE.
    - Interval = cycles between consecutive edge_pulses.
  - S_MEASURE, timeout: when units would reach 17 → speed_valid←0, rate_err←1, match_cnt←0, go to S_WAIT_EDGE. units saturates and never wraps (5-bit).
- Decode at an edge:
  - units==0 or units>16:
    - rate_err←1, speed_valid←0, match_cnt←0.
  - Otherwise:
    - cand = 16 − units (4-bit).
    - If cand==prev_cand: match_cnt←min(match_cnt+1, LOCK_COUNT). Else match_cnt←1.
    - prev_cand←cand.
  - When match_cnt reaches LOCK_COUNT:
    - speed_out←cand, speed_valid←1, rate_err←0.
    - Registered: visible the cycle after edge_pulse.
  - Candidate differs from speed_out while locked: speed_valid←0 immediately; speed_out holds its old value until relock.
- Edge on the same cycle as a frac_cnt wrap: the edge wins; that wrap's units increment is not counted.
- Reset mid-measurement: all state cleared. The first post-reset edge is only a reference; at least LOCK_COUNT+1 edges are needed to lock.

Decomposition:
- Package ftwb_blink_pkg:
  - SPEED_W=4, NUM_SPEEDS=16.
  - Function half_period_cycles(speed, base), shared with the transmitter counter and the benches.
  - Enum decoder_state_t {S_WAIT_EDGE, S_MEASURE}.
- Sub-module toggle_sync_edge: synchroniser plus edge detector. Parameter SYNC_STAGES; outputs sync level and edge_pulse. Reusable for buttons and inputs.

Test Plan (BASE_CYCLES=10, LOCK_COUNT=2, SYNC_STAGES=2):
- Reset held, toggle_in wiggling → all outputs 0, no edge_pulse while rst_n=0.
- Toggle with half-period 10 cycles (speed 15) → speed_valid=1 exactly one cycle after the 3rd edge_pulse, speed_out=15, rate_err=0.
- Half-period 110 then 114 then 106 cycles → every interval decodes to 5, so speed_out=5 and valid stays high. Next interval 116 → units=12, cand=4, speed_valid drops while speed_out stays 5. Another 120 → speed_out=4, valid=1.
- Interval of 4 cycles (units=0) → rate_err=1, speed_valid=0. Subsequent steady 160-cycle half-periods → speed_out=0, rate_err clears on lock.
- Locked at speed 0, then toggle_in held static → rate_err=1 and speed_valid=0 on the cycle units hits 17 (≈165 cycles after the last edge), FSM back in S_WAIT_EDGE.
- rst_n pulsed low mid-S_MEASURE while locked at speed 7 → outputs 0 asynchronously. After release, relock at 7 after the 3rd edge.
